// File: rtl/fp_align_pkg.sv
// ---------------------------------------------------------------------------
// fp_align_pkg
//   Shared definitions for the FP adder alignment stage (fp_align_shift) and
//   its sticky right-shifter (fp_rshift_sticky).
//
//   Contents:
//     EXP_W_DEF / MANT_W_DEF / SHIFT_STEP_DEF : default widths and step size
//     align_state_e                           : alignment FSM states
//     sat_min()                               : unsigned minimum, used to clamp
//                                               the exponent difference and the
//                                               per-cycle shift distance
// ---------------------------------------------------------------------------
package fp_align_pkg;

    localparam int EXP_W_DEF      = 8;
    localparam int MANT_W_DEF     = 28;
    localparam int SHIFT_STEP_DEF = 4;

    // IDLE  : waiting for operands, the only state that accepts
    // SHIFT : smaller mantissa is being moved right toward the big exponent
    // DONE  : aligned pair presented downstream until it is taken
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } align_state_e;

    // Unsigned minimum on 32-bit values; callers cast the result back down
    // to the width they need.
    function automatic logic [31:0] sat_min(input logic [31:0] a,
                                            input logic [31:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage : fp_align_pkg

// File: rtl/fp_rshift_sticky.sv
// ---------------------------------------------------------------------------
// fp_rshift_sticky
//   Combinational logical right shift of an extended mantissa with sticky
//   jamming: every bit that falls off the bottom (and the incoming bit 0,
//   which already carries earlier sticky information) is OR-ed into bit 0
//   of the result. A shift of zero passes the mantissa through untouched.
//
//   Parameters:
//     MANT_W  : mantissa width
//     SH_W    : width of the shift-amount port
//
//   Ports:
//     mant_i   in   MANT_W  mantissa to shift
//     shamt_i  in   SH_W    shift distance (values >= MANT_W flush to sticky)
//     mant_o   out  MANT_W  shifted mantissa, bit0 = sticky
// ---------------------------------------------------------------------------
module fp_rshift_sticky
    import fp_align_pkg::*;
#(
    parameter int MANT_W = MANT_W_DEF,
    parameter int SH_W   = 3
) (
    input  logic [MANT_W-1:0] mant_i,
    input  logic [SH_W-1:0]   shamt_i,
    output logic [MANT_W-1:0] mant_o
);

    logic [MANT_W-1:0] lostMask;
    logic [MANT_W-1:0] shifted;
    logic              jam;

    // lostMask has ones exactly on the bit positions shifted out; for a
    // non-zero shift that always includes bit 0, so the old sticky survives.
    always_comb begin
        lostMask = ~({MANT_W{1'b1}} << shamt_i);
        shifted  = mant_i >> shamt_i;
        jam      = |(mant_i & lostMask);
        mant_o   = {shifted[MANT_W-1:1], shifted[0] | jam};
    end

endmodule : fp_rshift_sticky

// File: rtl/fp_align_shift.sv
// ---------------------------------------------------------------------------
// fp_align_shift
//   Operand swap + exponent alignment stage of the FP adder, placed right
//   after the magnitude comparator. The comparator's less flag picks which
//   operand goes to the big path; the other mantissa is shifted right by the
//   exponent difference (clamped to MANT_W) with sticky jamming into bit 0.
//   Valid/ready handshake on both sides; one operation in flight at a time.
//
//   Build option (macro FP_ALIGN_BARREL_EN):
//     defined   : the whole remaining distance is shifted in one SHIFT cycle
//     undefined : at most SHIFT_STEP bit positions are shifted per cycle
//
//   Ports:
//     i_clk         in   1       clock
//     i_rst         in   1       asynchronous reset, active-high
//     i_valid       in   1       upstream operands valid
//     o_ready       out  1       stage can accept (IDLE only)
//     i_exp_a       in   EXP_W   exponent A
//     i_exp_b       in   EXP_W   exponent B
//     i_mant_a      in   MANT_W  mantissa A
//     i_mant_b      in   MANT_W  mantissa B
//     i_less        in   1       comparator flag, |A| < |B|
//     o_valid       out  1       aligned result valid
//     i_ready       in   1       downstream accepts result
//     o_swap        out  1       1 = B routed to big path
//     o_exp_big     out  EXP_W   exponent of larger operand
//     o_mant_big    out  MANT_W  larger mantissa, unshifted
//     o_mant_small  out  MANT_W  smaller mantissa, aligned, bit0 = sticky
// ---------------------------------------------------------------------------
module fp_align_shift
    import fp_align_pkg::*;
#(
    parameter int EXP_W      = EXP_W_DEF,
    parameter int MANT_W     = MANT_W_DEF,
    parameter int SHIFT_STEP = SHIFT_STEP_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [EXP_W-1:0]  i_exp_a,
    input  logic [EXP_W-1:0]  i_exp_b,
    input  logic [MANT_W-1:0] i_mant_a,
    input  logic [MANT_W-1:0] i_mant_b,
    input  logic              i_less,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_swap,
    output logic [EXP_W-1:0]  o_exp_big,
    output logic [MANT_W-1:0] o_mant_big,
    output logic [MANT_W-1:0] o_mant_small
);

    // Remaining distance never exceeds MANT_W, so it fits in REM_W bits.
    localparam int REM_W = $clog2(MANT_W + 1);
`ifdef FP_ALIGN_BARREL_EN
    localparam int MAX_SH = MANT_W;
`else
    localparam int MAX_SH = SHIFT_STEP;
`endif
    localparam int SH_W = $clog2(MAX_SH + 1);

    // Elaboration-time guard on the step size.
    if (SHIFT_STEP < 1 || SHIFT_STEP > MANT_W) begin : g_bad_step
        $error("fp_align_shift: SHIFT_STEP must lie in 1..MANT_W");
    end

    align_state_e      state_q,     state_d;
    logic [REM_W-1:0]  rem_q,       rem_d;
    logic              swap_q,      swap_d;
    logic [EXP_W-1:0]  expBig_q,    expBig_d;
    logic [MANT_W-1:0] mantBig_q,   mantBig_d;
    logic [MANT_W-1:0] mantSmall_q, mantSmall_d;

    logic [EXP_W-1:0]  accExpBig;
    logic [EXP_W-1:0]  accExpSmall;
    logic [EXP_W-1:0]  accDiff;
    logic [REM_W-1:0]  accRem;
    logic [REM_W-1:0]  step;
    logic [MANT_W-1:0] shiftedSmall;

    // Operand routing at accept time. A tie (less=0) keeps A on the big
    // path. The difference is taken modulo 2^EXP_W and then clamped, since
    // any shift of MANT_W or more leaves only the sticky bit.
    always_comb begin
        accExpBig   = i_less ? i_exp_b : i_exp_a;
        accExpSmall = i_less ? i_exp_a : i_exp_b;
        accDiff     = accExpBig - accExpSmall;
        accRem      = REM_W'(sat_min(32'(accDiff), 32'(MANT_W)));
    end

    // Distance handled this SHIFT cycle: everything that is left in the
    // barrel build, otherwise at most SHIFT_STEP positions.
    always_comb begin
`ifdef FP_ALIGN_BARREL_EN
        step = rem_q;
`else
        step = REM_W'(sat_min(32'(rem_q), 32'(SHIFT_STEP)));
`endif
    end

    fp_rshift_sticky #(
        .MANT_W (MANT_W),
        .SH_W   (SH_W)
    ) u_shift (
        .mant_i  (mantSmall_q),
        .shamt_i (SH_W'(step)),
        .mant_o  (shiftedSmall)
    );

    // Next-state logic: load in IDLE, walk the small mantissa in SHIFT,
    // hold everything in DONE until downstream takes it.
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        swap_d      = swap_q;
        expBig_d    = expBig_q;
        mantBig_d   = mantBig_q;
        mantSmall_d = mantSmall_q;

        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    swap_d      = i_less;
                    expBig_d    = accExpBig;
                    mantBig_d   = i_less ? i_mant_b : i_mant_a;
                    mantSmall_d = i_less ? i_mant_a : i_mant_b;
                    rem_d       = accRem;
                    state_d     = (accRem == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                mantSmall_d = shiftedSmall;
                rem_d       = rem_q - step;
                state_d     = (rem_q == step) ? DONE : SHIFT;
            end
            DONE: begin
                if (i_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            swap_q      <= 1'b0;
            expBig_q    <= '0;
            mantBig_q   <= '0;
            mantSmall_q <= '0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            swap_q      <= swap_d;
            expBig_q    <= expBig_d;
            mantBig_q   <= mantBig_d;
            mantSmall_q <= mantSmall_d;
        end
    end

    // Handshake flags are pure state decodes so reset clears them at once.
    always_comb begin
        o_ready      = (state_q == IDLE);
        o_valid      = (state_q == DONE);
        o_swap       = swap_q;
        o_exp_big    = expBig_q;
        o_mant_big   = mantBig_q;
        o_mant_small = mantSmall_q;
    end

endmodule : fp_align_shift

// File: tb/tb_fp_align_shift.sv
// ---------------------------------------------------------------------------
// tb_fp_align_shift
//   Self-checking bench for fp_align_shift: directed operand pairs, random
//   operands against an arithmetic reference model, back-pressure in DONE,
//   and asynchronous reset in the middle of a shift.
// ---------------------------------------------------------------------------
module tb_fp_align_shift;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic [7:0]  i_exp_a;
    logic [7:0]  i_exp_b;
    logic [27:0] i_mant_a;
    logic [27:0] i_mant_b;
    logic        i_less;
    logic        o_valid;
    logic        i_ready;
    logic        o_swap;
    logic [7:0]  o_exp_big;
    logic [27:0] o_mant_big;
    logic [27:0] o_mant_small;

    int nChecks = 0;
    int nFails  = 0;

    fp_align_shift #(
        .EXP_W      (8),
        .MANT_W     (28),
        .SHIFT_STEP (4)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_exp_a      (i_exp_a),
        .i_exp_b      (i_exp_b),
        .i_mant_a     (i_mant_a),
        .i_mant_b     (i_mant_b),
        .i_less       (i_less),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_swap       (o_swap),
        .o_exp_big    (o_exp_big),
        .o_mant_big   (o_mant_big),
        .o_mant_small (o_mant_small)
    );

    always #5 i_clk = ~i_clk;

    // Reference model: swap rule, modular exponent difference clamped to 28,
    // and the aligned value as (m / 2^rem) with the sticky bit set if any of
    // the discarded low bits (including bit 0) was one.
    function automatic void model(input logic [7:0] ea, input logic [7:0] eb,
                                  input logic [27:0] ma, input logic [27:0] mb,
                                  input logic less,
                                  output logic sw, output logic [7:0] ebig,
                                  output logic [27:0] mbig, output logic [27:0] msmall,
                                  output int lat);
        int d;
        int rem;
        longint unsigned m;
        longint unsigned lost;
        longint unsigned res;
        sw   = less;
        ebig = less ? eb : ea;
        mbig = less ? mb : ma;
        m    = less ? longint'(ma) : longint'(mb);
        d    = less ? (int'(eb) - int'(ea) + 256) % 256 : (int'(ea) - int'(eb) + 256) % 256;
        rem  = (d < 28) ? d : 28;
        if (rem == 0) begin
            res = m;
        end else begin
            lost = m % (64'd1 << rem);
            res  = (m >> rem) | ((lost != 0) ? 64'd1 : 64'd0);
        end
        msmall = 28'(res);
`ifdef FP_ALIGN_BARREL_EN
        lat = (rem == 0) ? 1 : 2;
`else
        lat = 1 + (rem + 3) / 4;
`endif
    endfunction

    // Waits for o_ready, presents one operation for a single accept edge,
    // then counts falling edges until o_valid is seen (1 = the edge after
    // the accept edge). Leaves the result waiting with i_ready low.
    task automatic applyStimulus(input logic [7:0] ea, input logic [7:0] eb,
                                 input logic [27:0] ma, input logic [27:0] mb,
                                 input logic less,
                                 output int lat, output logic timedOut);
        int guard = 0;
        @(negedge i_clk);
        while (!o_ready && guard < 50) begin
            @(negedge i_clk);
            guard++;
        end
        i_exp_a  = ea;
        i_exp_b  = eb;
        i_mant_a = ma;
        i_mant_b = mb;
        i_less   = less;
        i_valid  = 1'b1;
        @(posedge i_clk);
        #1 i_valid = 1'b0;
        lat      = 0;
        timedOut = 1'b1;
        for (int c = 1; c <= 100; c++) begin
            @(negedge i_clk);
            if (o_valid) begin
                lat      = c;
                timedOut = 1'b0;
                break;
            end
        end
    endtask

    task automatic releaseResult();
        i_ready = 1'b1;
        @(posedge i_clk);
        #1 i_ready = 1'b0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        #1;
        nChecks++;
        if (o_valid !== 1'b0) begin nFails++; $display("[TB] FAIL reset_valid got=%b exp=0", o_valid); end
        nChecks++;
        if (o_ready !== 1'b1) begin nFails++; $display("[TB] FAIL reset_ready got=%b exp=1", o_ready); end
        nChecks++;
        if (o_mant_small !== 28'h0 || o_mant_big !== 28'h0) begin
            nFails++;
            $display("[TB] FAIL reset_mant got=%h/%h exp=0/0", o_mant_big, o_mant_small);
        end
        nChecks++;
        if (o_exp_big !== 8'h0 || o_swap !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL reset_exp got=%h/%b exp=00/0", o_exp_big, o_swap);
        end
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        nChecks++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL post_reset_idle got=%b%b exp=10", o_ready, o_valid);
        end
    endtask

    // Directed operand pairs with hand-derived results.
    task automatic test_directed();
        logic [7:0]  ea [4] = '{8'h85, 8'h80, 8'h90, 8'h7F};
        logic [7:0]  eb [4] = '{8'h82, 8'h88, 8'h10, 8'h7F};
        logic [27:0] ma [4] = '{28'h8000000, 28'h80000FF, 28'h8000000, 28'h4000000};
        logic [27:0] mb [4] = '{28'hC000000, 28'h9000000, 28'h0000002, 28'h4000000};
        logic        ls [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic        xs [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [7:0]  xe [4] = '{8'h85, 8'h88, 8'h90, 8'h7F};
        logic [27:0] xb [4] = '{28'h8000000, 28'h9000000, 28'h8000000, 28'h4000000};
        logic [27:0] xm [4] = '{28'h1800000, 28'h0080001, 28'h0000001, 28'h4000000};
`ifdef FP_ALIGN_BARREL_EN
        int          xl [4] = '{2, 2, 2, 1};
`else
        int          xl [4] = '{2, 3, 8, 1};
`endif
        int   lat;
        logic tout;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(ea[i], eb[i], ma[i], mb[i], ls[i], lat, tout);
            nChecks++;
            if (tout || lat != xl[i]) begin
                nFails++;
                $display("[TB] FAIL dir%0d_latency got=%0d (timeout=%b) exp=%0d", i + 1, lat, tout, xl[i]);
            end
            nChecks++;
            if (o_swap !== xs[i] || o_exp_big !== xe[i]) begin
                nFails++;
                $display("[TB] FAIL dir%0d_swap_exp got=%b/%h exp=%b/%h", i + 1, o_swap, o_exp_big, xs[i], xe[i]);
            end
            nChecks++;
            if (o_mant_big !== xb[i] || o_mant_small !== xm[i]) begin
                nFails++;
                $display("[TB] FAIL dir%0d_mant got=%h/%h exp=%h/%h", i + 1, o_mant_big, o_mant_small, xb[i], xm[i]);
            end
            releaseResult();
        end
    endtask

    // Random operands with exponent gaps spanning 0..35, wrap-around included.
    task automatic test_random();
        logic [7:0]  ea, eb, xe;
        logic [27:0] ma, mb, xb, xm;
        logic        ls, xs, tout;
        int          xl, lat, delta;
        for (int n = 0; n < 40; n++) begin
            ea    = 8'($urandom);
            delta = $urandom_range(0, 35);
            eb    = ($urandom_range(0, 1) == 1) ? 8'(ea + delta) : 8'(ea - delta);
            ma    = 28'($urandom);
            mb    = 28'($urandom);
            if ($urandom_range(0, 3) == 0) mb = ma;
            ls    = (ea < eb) || (ea == eb && ma < mb);
            model(ea, eb, ma, mb, ls, xs, xe, xb, xm, xl);
            applyStimulus(ea, eb, ma, mb, ls, lat, tout);
            nChecks++;
            if (tout || lat != xl) begin
                nFails++;
                $display("[TB] FAIL rnd%0d_latency got=%0d exp=%0d", n, lat, xl);
            end
            nChecks++;
            if (o_swap !== xs || o_exp_big !== xe || o_mant_big !== xb || o_mant_small !== xm) begin
                nFails++;
                $display("[TB] FAIL rnd%0d_data got=%b/%h/%h/%h exp=%b/%h/%h/%h",
                         n, o_swap, o_exp_big, o_mant_big, o_mant_small, xs, xe, xb, xm);
            end
            repeat ($urandom_range(0, 2)) @(negedge i_clk);
            releaseResult();
        end
    endtask

    // Results must hold while downstream stalls, even with a new operand
    // waiting; the waiting operand is taken the cycle after the handshake.
    task automatic test_back_to_back();
        logic [7:0]  xe, xe2;
        logic [27:0] xb, xm, xb2, xm2;
        logic        xs, xs2, tout;
        int          xl, xl2, lat;
        model(8'h85, 8'h82, 28'h8000000, 28'hC000000, 1'b0, xs, xe, xb, xm, xl);
        model(8'h40, 8'h4A, 28'h1234567, 28'hABCDEF1, 1'b1, xs2, xe2, xb2, xm2, xl2);
        applyStimulus(8'h85, 8'h82, 28'h8000000, 28'hC000000, 1'b0, lat, tout);
        i_exp_a  = 8'h40;
        i_exp_b  = 8'h4A;
        i_mant_a = 28'h1234567;
        i_mant_b = 28'hABCDEF1;
        i_less   = 1'b1;
        i_valid  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge i_clk);
            nChecks++;
            if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_swap !== xs || o_exp_big !== xe ||
                o_mant_big !== xb || o_mant_small !== xm) begin
                nFails++;
                $display("[TB] FAIL stall%0d got=%b%b %b/%h/%h/%h exp=10 %b/%h/%h/%h",
                         c, o_valid, o_ready, o_swap, o_exp_big, o_mant_big, o_mant_small, xs, xe, xb, xm);
            end
        end
        i_ready = 1'b1;
        @(posedge i_clk);
        #1 i_ready = 1'b0;
        nChecks++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL after_handshake got=%b%b exp=10", o_ready, o_valid);
        end
        @(posedge i_clk);
        #1 i_valid = 1'b0;
        nChecks++;
        if (o_ready !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL next_accept got=%b exp=0", o_ready);
        end
        lat  = 0;
        tout = 1'b1;
        for (int c = 1; c <= 100; c++) begin
            @(negedge i_clk);
            if (o_valid) begin lat = c; tout = 1'b0; break; end
        end
        nChecks++;
        if (tout || lat != xl2 || o_swap !== xs2 || o_exp_big !== xe2 ||
            o_mant_big !== xb2 || o_mant_small !== xm2) begin
            nFails++;
            $display("[TB] FAIL next_op got=%0d %b/%h/%h/%h exp=%0d %b/%h/%h/%h",
                     lat, o_swap, o_exp_big, o_mant_big, o_mant_small, xl2, xs2, xe2, xb2, xm2);
        end
        releaseResult();
    endtask

    // Reset asserted between clock edges while a long shift is running.
    task automatic test_reset_midshift();
        logic [7:0]  xe;
        logic [27:0] xb, xm;
        logic        xs, tout;
        int          xl, lat;
        @(negedge i_clk);
        i_exp_a  = 8'h90;
        i_exp_b  = 8'h10;
        i_mant_a = 28'h8000000;
        i_mant_b = 28'hFFFFFFF;
        i_less   = 1'b0;
        i_valid  = 1'b1;
        @(posedge i_clk);
        #1 i_valid = 1'b0;
        @(negedge i_clk);
        @(negedge i_clk);
        #2 i_rst = 1'b1;
        #1;
        nChecks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL midshift_reset_flags got=%b%b exp=01", o_valid, o_ready);
        end
        nChecks++;
        if (o_mant_small !== 28'h0 || o_mant_big !== 28'h0 || o_exp_big !== 8'h0 || o_swap !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL midshift_reset_data got=%b/%h/%h/%h exp=0/00/0/0",
                     o_swap, o_exp_big, o_mant_big, o_mant_small);
        end
        @(negedge i_clk);
        i_rst = 1'b0;
        model(8'h83, 8'h87, 28'h0F0F0F0, 28'h8888888, 1'b1, xs, xe, xb, xm, xl);
        applyStimulus(8'h83, 8'h87, 28'h0F0F0F0, 28'h8888888, 1'b1, lat, tout);
        nChecks++;
        if (tout || lat != xl || o_swap !== xs || o_exp_big !== xe ||
            o_mant_big !== xb || o_mant_small !== xm) begin
            nFails++;
            $display("[TB] FAIL post_reset_op got=%0d %b/%h/%h/%h exp=%0d %b/%h/%h/%h",
                     lat, o_swap, o_exp_big, o_mant_big, o_mant_small, xl, xs, xe, xb, xm);
        end
        releaseResult();
    endtask

    // Top-level sequence of scenarios.
    initial begin
        i_rst    = 1'b1;
        i_valid  = 1'b0;
        i_ready  = 1'b0;
        i_exp_a  = '0;
        i_exp_b  = '0;
        i_mant_a = '0;
        i_mant_b = '0;
        i_less   = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_midshift();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule : tb_fp_align_shift
